btb_predictor: RTL
==================

# btb_predictor

Branch target buffer and direction predictor for the IF stage. It is the producer of the `btb_hit` prediction that travels down the pipe to EX-stage branch resolution. Each cycle it looks up the fetch PC and reports a predicted-taken hit with its target. EX-stage branch resolution writes back the actual outcome, which allocates or trains entries.

## Interface
- `ENTRIES`, 16, number of direct-mapped entries (power of 2, ≥2)
- `PC_W`, 16, instruction address width
- `IDX_W`, `$clog2(ENTRIES)`, derived index width (localparam)

- `clk`  in  1  system clock, all state updates on posedge
- `rst`  in  1  reset, synchronous, active-high: all entries invalid, all counters = 2'b01
- `pc_IF`  in  PC_W  fetch address to look up
- `btb_hit_IF`  out  1  predicted taken: entry valid & tag match & counter[1]
- `btb_target_IF`  out  PC_W  predicted target; 0 when `btb_hit_IF`=0
- `upd_en_EX`  in  1  a conditional branch resolved in EX this cycle
- `upd_pc_EX`  in  PC_W  address of the resolved branch
- `upd_taken_EX`  in  1  actual outcome (1 = taken)
- `upd_target_EX`  in  PC_W  actual computed branch target
- `flush_btb`  in  1  invalidate every entry (same effect as reset on valid bits only)

## Operation
- Entry = {valid, tag[PC_W-IDX_W], target[PC_W], cnt[2]}; index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturating.
- Lookup is purely combinational from `pc_IF` and current table state.
- Update when `upd_en_EX`=1, indexed by `upd_pc_EX`:
  - hit (valid & tag match), taken: cnt = sat_inc(cnt), target <= `upd_target_EX`.
  - hit, not taken: cnt = sat_dec(cnt); target unchanged.
  - miss, taken: allocate/replace: valid=1, tag, target written, cnt=2'b10.
  - miss, not taken: no change (no allocation of not-taken branches).
- Jumps are never presented on `upd_en_EX`; they are not predicted.
- `flush_btb`=1: all valid <= 0 next edge; counters/tags/targets unchanged. If `upd_en_EX` is also 1 in that cycle, flush wins and no allocation occurs.
- `rst` has priority over flush and update.

## Timing
- Lookup latency 0: `btb_hit_IF`/`btb_target_IF` valid in the same cycle as `pc_IF`.
- Update latency 1: a write at edge N is visible to lookups from cycle N+1 onward.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state (no bypass).
- Reset values: `btb_hit_IF`=0 and `btb_target_IF`=0 from the cycle after `rst` is sampled high, and for as long as `rst` stays high.
- Aliasing: two PCs with equal index and different tags replace each other; only allocation on a taken miss evicts.
- A counter at 11 stays 11 on taken. A counter at 00 stays 00 on not taken. An entry is never invalidated by counter value.

## Structure
- Shared package `btb_pkg`: counter encodings (`CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`) and the default `ENTRIES`/`PC_W`.
- Sub-module `sat_cnt2`: combinational 2-bit saturating inc/dec, (cnt, taken) -> next cnt; used once in the update path.
- Storage in flop arrays (valid vector, tag/target/cnt arrays); no RAM macro, because the read must be asynchronous.

## Test plan
- Reset with `rst`=1 for 2 cycles, then lookup of pc 0x0000 through 0x000F -> `btb_hit_IF`=0 and `btb_target_IF`=0 for every PC.
- Update pc=0x0034, taken, target=0x0050, then lookup 0x0034 next cycle -> hit=1, target=0x0050; lookup 0x0044 (same index, other tag) -> hit=0.
- Present the 0x0034 entry not-taken twice -> cnt 10->01->00, lookup hit=0. Then taken once -> cnt 01, hit still 0. Taken again -> cnt 10, hit=1.
- Update pc=0x0012 with not-taken on an empty table -> no allocation; a later lookup of 0x0012 -> hit=0.
- Same cycle: `pc_IF`=0x0034 while update allocates 0x0034 taken -> hit=0 that cycle and hit=1 the next cycle.
- With 0x0034 valid, assert `flush_btb` together with `upd_en_EX` (pc 0x0021, taken) -> the next cycle shows hit=0 for both 0x0034 and 0x0021.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: 2-bit counter encodings and
// default geometry.
package btb_pkg;
  localparam int BTB_ENTRIES = 16;
  localparam int BTB_PC_W    = 16;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;
endpackage

// File: rtl/btb_predictor_sat_cnt2.sv
// Combinational 2-bit saturating counter step: increment on taken, decrement
// on not-taken, clamping at the strong states.
module sat_cnt2
  import btb_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'b01;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'b01;
    end
  end
endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup from
// the fetch PC, one-cycle-latency training from EX branch resolution.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int PC_W    = BTB_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_IF,
  output logic            btb_hit_IF,
  output logic [PC_W-1:0] btb_target_IF,
  input  logic            upd_en_EX,
  input  logic [PC_W-1:0] upd_pc_EX,
  input  logic            upd_taken_EX,
  input  logic [PC_W-1:0] upd_target_EX,
  input  logic            flush_btb
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0] valid_vec;
  logic [TAG_W-1:0]   tag_arr    [ENTRIES];
  logic [PC_W-1:0]    target_arr [ENTRIES];
  logic [1:0]         cnt_arr    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_match, up_hit, do_write;
  logic [1:0]       cnt_trained, new_cnt;
  logic [PC_W-1:0]  new_target;

  assign lk_idx = pc_IF[IDX_W-1:0];
  assign lk_tag = pc_IF[PC_W-1:IDX_W];
  assign up_idx = upd_pc_EX[IDX_W-1:0];
  assign up_tag = upd_pc_EX[PC_W-1:IDX_W];

  // Lookup reads the pre-update table; there is deliberately no bypass.
  assign lk_match      = valid_vec[lk_idx] && (tag_arr[lk_idx] == lk_tag);
  assign btb_hit_IF    = lk_match && cnt_arr[lk_idx][1];
  assign btb_target_IF = btb_hit_IF ? target_arr[lk_idx] : '0;

  assign up_hit = valid_vec[up_idx] && (tag_arr[up_idx] == up_tag);

  sat_cnt2 u_sat_cnt2 (
    .cnt_i   (cnt_arr[up_idx]),
    .taken_i (upd_taken_EX),
    .cnt_o   (cnt_trained)
  );

  // Not-taken misses never allocate; a flush in the same cycle suppresses the write.
  assign do_write   = upd_en_EX && !flush_btb && (up_hit || upd_taken_EX);
  assign new_cnt    = up_hit ? cnt_trained : CNT_WT;
  assign new_target = upd_taken_EX ? upd_target_EX : target_arr[up_idx];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             sel;

    assign sel = do_write && (up_idx == IDX_W'(gi));

    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (flush_btb) begin
        valid_d = 1'b0;
      end else if (sel) begin
        valid_d  = 1'b1;
        tag_d    = up_tag;
        target_d = new_target;
        cnt_d    = new_cnt;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        cnt_q    <= CNT_WNT;
      end else begin
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
        cnt_q    <= cnt_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign tag_arr[gi]    = tag_q;
    assign target_arr[gi] = target_q;
    assign cnt_arr[gi]    = cnt_q;
  end
endmodule
